// File: rtl/block_lock_fsm_pkg.sv
// Shared 10GBASE-R PCS receive definitions: lock FSM states, sync header codes
// and default lock/slip thresholds.
package block_lock_fsm_pkg;

  typedef enum logic [1:0] {
    INIT      = 2'd0,
    HUNT      = 2'd1,
    LOCKED    = 2'd2,
    SLIP_WAIT = 2'd3
  } lock_fsm_e;

  localparam logic [1:0] SYNC_HEAD_DATA = 2'b01;
  localparam logic [1:0] SYNC_HEAD_CTRL = 2'b10;

  localparam int unsigned HEAD_W_DEF       = 2;
  localparam int unsigned SH_GOOD_CNT_DEF  = 64;
  localparam int unsigned SH_INVLD_MAX_DEF = 16;
  localparam int unsigned SLIP_WAIT_DEF    = 2;
  localparam int unsigned SLIP_CNT_W       = 8;

endpackage

// File: rtl/block_lock_fsm.sv
// Receive block lock controller: slips the gearbox until a run of valid sync
// headers is seen, then monitors the invalid-header rate per window.
module block_lock_fsm #(
  parameter int unsigned HEAD_W       = block_lock_fsm_pkg::HEAD_W_DEF,
  parameter int unsigned SH_GOOD_CNT  = block_lock_fsm_pkg::SH_GOOD_CNT_DEF,
  parameter int unsigned SH_INVLD_MAX = block_lock_fsm_pkg::SH_INVLD_MAX_DEF,
  parameter int unsigned SLIP_WAIT    = block_lock_fsm_pkg::SLIP_WAIT_DEF
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              signal_ok_i,
  input  logic              valid_i,
  input  logic [HEAD_W-1:0] head_i,
  output logic              slip_v_o,
  output logic              block_lock_o,
  output logic              sh_invld_o,
  output logic [7:0]        slip_cnt_o
);
  import block_lock_fsm_pkg::*;

  localparam int unsigned SH_CNT_W  = $clog2(SH_GOOD_CNT + 1);
  localparam int unsigned INV_CNT_W = $clog2(SH_INVLD_MAX + 1);
  localparam int unsigned WAIT_W    = $clog2(SLIP_WAIT + 1);

  lock_fsm_e              r_state, w_state_nxt;
  logic [SH_CNT_W-1:0]    r_sh_cnt, w_sh_cnt_nxt;
  logic [INV_CNT_W-1:0]   r_invld_cnt, w_invld_cnt_nxt;
  logic [WAIT_W-1:0]      r_wait_cnt, w_wait_cnt_nxt;
  logic [SLIP_CNT_W-1:0]  r_slip_cnt, w_slip_cnt_nxt;
  logic                   r_slip, w_slip;
  logic                   r_sh_invld, w_sh_invld;
  logic                   r_block_lock;
  logic                   w_head_legal, w_sh_ok, w_sh_bad;

  assign w_head_legal = (head_i == HEAD_W'(SYNC_HEAD_DATA)) ||
                        (head_i == HEAD_W'(SYNC_HEAD_CTRL));
  assign w_sh_ok  = valid_i &  w_head_legal;
  assign w_sh_bad = valid_i & ~w_head_legal;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state      <= INIT;
      r_sh_cnt     <= '0;
      r_invld_cnt  <= '0;
      r_wait_cnt   <= '0;
      r_slip_cnt   <= '0;
      r_slip       <= 1'b0;
      r_sh_invld   <= 1'b0;
      r_block_lock <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sh_cnt     <= w_sh_cnt_nxt;
      r_invld_cnt  <= w_invld_cnt_nxt;
      r_wait_cnt   <= w_wait_cnt_nxt;
      r_slip_cnt   <= w_slip_cnt_nxt;
      r_slip       <= w_slip;
      r_sh_invld   <= w_sh_invld;
      r_block_lock <= (w_state_nxt == LOCKED);
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_sh_cnt_nxt    = r_sh_cnt;
    w_invld_cnt_nxt = r_invld_cnt;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_slip          = 1'b0;
    w_sh_invld      = 1'b0;

    if (!signal_ok_i) begin
      w_state_nxt     = INIT;
      w_sh_cnt_nxt    = '0;
      w_invld_cnt_nxt = '0;
      w_wait_cnt_nxt  = '0;
    end else begin
      case (r_state)
        INIT: begin
          w_sh_cnt_nxt    = '0;
          w_invld_cnt_nxt = '0;
          w_wait_cnt_nxt  = '0;
          w_state_nxt     = HUNT;
        end
        HUNT: begin
          if (w_sh_bad) begin
            w_sh_invld   = 1'b1;
            w_slip       = 1'b1;
            w_sh_cnt_nxt = '0;
            w_state_nxt  = block_lock_fsm_pkg::SLIP_WAIT;
          end else if (w_sh_ok) begin
            if (r_sh_cnt == SH_CNT_W'(SH_GOOD_CNT - 1)) begin
              w_sh_cnt_nxt    = '0;
              w_invld_cnt_nxt = '0;
              w_state_nxt     = LOCKED;
            end else begin
              w_sh_cnt_nxt = r_sh_cnt + SH_CNT_W'(1);
            end
          end
        end
        LOCKED: begin
          // Loss of lock takes priority over the end-of-window clear.
          if (valid_i) begin
            w_sh_invld = w_sh_bad;
            if (w_sh_bad && (r_invld_cnt == INV_CNT_W'(SH_INVLD_MAX - 1))) begin
              w_slip          = 1'b1;
              w_sh_cnt_nxt    = '0;
              w_invld_cnt_nxt = '0;
              w_state_nxt     = block_lock_fsm_pkg::SLIP_WAIT;
            end else if (r_sh_cnt == SH_CNT_W'(SH_GOOD_CNT - 1)) begin
              w_sh_cnt_nxt    = '0;
              w_invld_cnt_nxt = '0;
            end else begin
              w_sh_cnt_nxt    = r_sh_cnt + SH_CNT_W'(1);
              w_invld_cnt_nxt = r_invld_cnt + INV_CNT_W'(w_sh_bad);
            end
          end
        end
        block_lock_fsm_pkg::SLIP_WAIT: begin
          if (valid_i) begin
            if (r_wait_cnt == WAIT_W'(SLIP_WAIT - 1)) begin
              w_wait_cnt_nxt = '0;
              w_state_nxt    = HUNT;
            end else begin
              w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
            end
          end
        end
        default: w_state_nxt = INIT;
      endcase
    end
  end

  // Slip counter saturates and restarts whenever the controller drops to INIT.
  always_comb begin
    w_slip_cnt_nxt = r_slip_cnt;
    if (!signal_ok_i) begin
      w_slip_cnt_nxt = '0;
    end else if (w_slip && (r_slip_cnt != {SLIP_CNT_W{1'b1}})) begin
      w_slip_cnt_nxt = r_slip_cnt + SLIP_CNT_W'(1);
    end
  end

  assign slip_v_o     = r_slip;
  assign block_lock_o = r_block_lock;
  assign sh_invld_o   = r_sh_invld;
  assign slip_cnt_o   = r_slip_cnt;

endmodule

// File: tb/tb_block_lock_fsm.sv
// Directed bench for block_lock_fsm: vector table for the basic flow plus
// hand sequences for window, simultaneous-event, idle and reset corners.
module tb_block_lock_fsm;

  logic       clk;
  logic       nreset;
  logic       signal_ok;
  logic       valid;
  logic [1:0] head;
  logic       slip_v;
  logic       block_lock;
  logic       sh_invld;
  logic [7:0] slip_cnt;

  int errors;
  int checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  block_lock_fsm dut (
    .clk          (clk),
    .nreset       (nreset),
    .signal_ok_i  (signal_ok),
    .valid_i      (valid),
    .head_i       (head),
    .slip_v_o     (slip_v),
    .block_lock_o (block_lock),
    .sh_invld_o   (sh_invld),
    .slip_cnt_o   (slip_cnt)
  );

  typedef struct {
    int         reps;
    logic       sok;
    logic       vld;
    logic [1:0] hd;
    logic       e_slip;
    logic       e_lock;
    logic       e_invld;
    logic [7:0] e_scnt;
    string      name;
  } vec_t;

  task automatic step(input logic sok, input logic vld, input logic [1:0] hd);
    signal_ok = sok;
    valid     = vld;
    head      = hd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic es, input logic el,
                         input logic ei, input logic [7:0] ec);
    chk({name, ".slip"},     8'(slip_v),     8'(es));
    chk({name, ".lock"},     8'(block_lock), 8'(el));
    chk({name, ".invld"},    8'(sh_invld),   8'(ei));
    chk({name, ".slip_cnt"}, slip_cnt,       ec);
  endtask

  vec_t vecs[14];

  initial begin
    errors    = 0;
    checks    = 0;
    nreset    = 1'b0;
    signal_ok = 1'b1;
    valid     = 1'b0;
    head      = 2'b00;

    vecs[0]  = '{1,  1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, "init_to_hunt"};
    vecs[1]  = '{63, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 8'd0, "hunt_63"};
    vecs[2]  = '{1,  1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 8'd0, "lock_64th"};
    vecs[3]  = '{1,  1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 8'd0, "locked_bad"};
    vecs[4]  = '{1,  1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 8'd0, "locked_good"};
    vecs[5]  = '{1,  1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 8'd0, "sigok_drop_locked"};
    vecs[6]  = '{1,  1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 8'd0, "reinit"};
    vecs[7]  = '{10, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 8'd0, "hunt_10"};
    vecs[8]  = '{1,  1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 8'd1, "hunt_bad_slip"};
    vecs[9]  = '{1,  1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 8'd1, "wait_1"};
    vecs[10] = '{1,  1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 8'd1, "wait_idle"};
    vecs[11] = '{1,  1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'd1, "wait_2_ignored"};
    vecs[12] = '{63, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 8'd1, "rehunt_63"};
    vecs[13] = '{1,  1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 8'd1, "relock"};

    #1;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    nreset = 1'b1;

    for (int v = 0; v < 14; v++) begin
      for (int r = 0; r < vecs[v].reps; r++) begin
        step(vecs[v].sok, vecs[v].vld, vecs[v].hd);
        if (r < vecs[v].reps - 1) begin
          chk({vecs[v].name, ".mid_slip"}, 8'(slip_v), 8'd0);
          chk({vecs[v].name, ".mid_lock"}, 8'(block_lock), 8'(vecs[v].e_lock));
        end
      end
      chk_all(vecs[v].name, vecs[v].e_slip, vecs[v].e_lock, vecs[v].e_invld, vecs[v].e_scnt);
    end

    // 15 invalid headers in one window: lock held, window clears.
    for (int i = 0; i < 64; i++) begin
      logic [1:0] hd;
      hd = ((i % 4 == 0) && (i < 60)) ? 2'b11 : 2'b01;
      step(1'b1, 1'b1, hd);
      chk("win15.lock", 8'(block_lock), 8'd1);
      chk("win15.invld", 8'(sh_invld), 8'((hd == 2'b11) ? 1 : 0));
    end
    // Next window starts from zero: only the 16th bad header drops lock.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 2'b00);
      if (i < 15) begin
        chk("win16.held", 8'(block_lock), 8'd1);
        chk("win16.noslip", 8'(slip_v), 8'd0);
      end else begin
        chk_all("win16.lost", 1'b1, 1'b0, 1'b1, 8'd2);
      end
    end
    step(1'b1, 1'b1, 2'b01);
    chk("win16.one_cycle_slip", 8'(slip_v), 8'd0);
    step(1'b1, 1'b1, 2'b01);
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 1'b1, 2'b01);
      if (i == 62) chk("relock2.pre", 8'(block_lock), 8'd0);
    end
    chk_all("relock2", 1'b0, 1'b1, 1'b0, 8'd2);

    // 16th invalid is also the 64th header of the window.
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 1'b1, (i < 48) ? 2'b01 : 2'b11);
      if (i == 62) chk("edge.pre", 8'(block_lock), 8'd1);
    end
    chk_all("edge.slip_wins", 1'b1, 1'b0, 1'b1, 8'd3);

    // Invalid header at HUNT count 63: slip, no lock.
    step(1'b1, 1'b1, 2'b01);
    step(1'b1, 1'b1, 2'b01);
    for (int i = 0; i < 63; i++) step(1'b1, 1'b1, 2'b10);
    chk("hunt63.pre", 8'(block_lock), 8'd0);
    step(1'b1, 1'b1, 2'b11);
    chk_all("hunt63.bad", 1'b1, 1'b0, 1'b1, 8'd4);
    step(1'b1, 1'b1, 2'b01);
    step(1'b1, 1'b1, 2'b01);

    // Idle cycle every 32 cycles: lock after exactly 64 evaluated headers.
    begin
      int evald;
      int cyc;
      evald = 0;
      cyc   = 0;
      while (evald < 64 && cyc < 200) begin
        logic vld;
        vld = (cyc % 32) != 31;
        step(1'b1, vld, 2'b01);
        if (vld) evald++;
        if (evald == 63) chk("idle.pre", 8'(block_lock), 8'd0);
        cyc++;
      end
      chk("idle.evald", 8'(evald), 8'd64);
      chk_all("idle.lock", 1'b0, 1'b1, 1'b0, 8'd4);
    end
    step(1'b1, 1'b0, 2'b11);
    chk_all("idle.bad_ignored", 1'b0, 1'b1, 1'b0, 8'd4);

    // Asynchronous reset mid-operation.
    nreset = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 1'b0, 1'b0, 8'd0);
    @(posedge clk);
    #1;
    chk_all("async_rst_hold", 1'b0, 1'b0, 1'b0, 8'd0);
    nreset = 1'b1;

    // signal_ok drop mid-HUNT clears the slip count with no slip pulse.
    step(1'b1, 1'b1, 2'b01);
    step(1'b1, 1'b1, 2'b11);
    chk_all("hunt.slip", 1'b1, 1'b0, 1'b1, 8'd1);
    step(1'b1, 1'b1, 2'b01);
    step(1'b1, 1'b1, 2'b01);
    repeat (5) step(1'b1, 1'b1, 2'b01);
    step(1'b0, 1'b1, 2'b11);
    chk_all("sigok_drop_hunt", 1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b1, 2'b11);
    chk_all("init_ignores_hdr", 1'b0, 1'b0, 1'b0, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
